// File: rtl/alu_pkg.sv
// Shared ALU definitions: select codes, RV32I opcode/funct7 constants and a
// funct3-to-select helper used by the issue decoder and the ALU itself.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_SRA   = 4'b0110,
    ALU_SUB   = 4'b0111,
    ALU_OR    = 4'b1000,
    ALU_AND   = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_sel_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Base-encoding mapping (funct7 = 0); SUB/SRA are chosen by the caller.
  function automatic alu_sel_e funct3_sel(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational RV32I integer-op decode: select code, operands, destination
// and legality for OP, OP-IMM, LUI and AUIPC.
module alu_op_decode
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] rs1_i,
  input  logic [WIDTH-1:0] rs2_i,
  output logic [3:0]       alu_sel_o,
  output logic [WIDTH-1:0] op_a_o,
  output logic [WIDTH-1:0] op_b_o,
  output logic [4:0]       rd_o,
  output logic             rd_we_o,
  output logic             illegal_o
);

  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [WIDTH-1:0] imm_i;
  logic [WIDTH-1:0] imm_u;
  logic [WIDTH-1:0] shamt;
  alu_sel_e         sel;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             legal;

  assign opcode = instr_i[6:0];
  assign f3     = instr_i[14:12];
  assign f7     = instr_i[31:25];
  assign imm_i  = WIDTH'($signed(instr_i[31:20]));
  assign imm_u  = WIDTH'($signed({instr_i[31:12], 12'b0}));
  assign shamt  = WIDTH'(instr_i[24:20]);

  always_comb begin
    sel   = ALU_ADD;
    op_a  = '0;
    op_b  = '0;
    legal = 1'b0;
    if (instr_i[1:0] == 2'b11) begin
      case (opcode)
        OPC_OP: begin
          op_a = rs1_i;
          op_b = rs2_i;
          if (f7 == F7_BASE) begin
            legal = 1'b1;
            sel   = funct3_sel(f3);
          end else if (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101)) begin
            legal = 1'b1;
            sel   = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
          end
        end
        OPC_OP_IMM: begin
          op_a = rs1_i;
          op_b = imm_i;
          case (f3)
            3'b001: begin
              op_b  = shamt;
              sel   = ALU_SLL;
              legal = (f7 == F7_BASE);
            end
            3'b101: begin
              op_b  = shamt;
              sel   = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
              legal = (f7 == F7_BASE) || (f7 == F7_ALT);
            end
            default: begin
              sel   = funct3_sel(f3);
              legal = 1'b1;
            end
          endcase
        end
        OPC_LUI: begin
          sel   = ALU_PASSB;
          op_b  = imm_u;
          legal = 1'b1;
        end
        OPC_AUIPC: begin
          op_a  = pc_i;
          op_b  = imm_u;
          legal = 1'b1;
        end
        default: legal = 1'b0;
      endcase
    end
    // Unsupported encodings issue as a harmless ADD 0,0 with no writeback.
    if (!legal) begin
      sel  = ALU_ADD;
      op_a = '0;
      op_b = '0;
    end
  end

  assign alu_sel_o = sel;
  assign op_a_o    = op_a;
  assign op_b_o    = op_b;
  assign rd_o      = instr_i[11:7];
  assign rd_we_o   = legal && (instr_i[11:7] != 5'd0);
  assign illegal_o = !legal;

endmodule

// File: rtl/alu_op_issue.sv
// Single-slot issue register between register-file read and the ALU, with a
// valid/ready handshake on both sides and a flush that empties the slot.
module alu_op_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_rs1_data,
  input  logic [WIDTH-1:0] in_rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alu_sel,
  output logic [WIDTH-1:0] out_op_a,
  output logic [WIDTH-1:0] out_op_b,
  output logic [4:0]       out_rd,
  output logic             out_rd_we,
  output logic             out_illegal,
  output logic [WIDTH-1:0] out_pc
);

  logic [3:0]       dec_sel;
  logic [WIDTH-1:0] dec_op_a;
  logic [WIDTH-1:0] dec_op_b;
  logic [4:0]       dec_rd;
  logic             dec_rd_we;
  logic             dec_illegal;

  logic             valid_q;
  logic [3:0]       sel_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [4:0]       rd_q;
  logic             rd_we_q;
  logic             illegal_q;
  logic [WIDTH-1:0] pc_q;

  alu_op_decode #(.WIDTH(WIDTH)) u_decode (
    .instr_i   (in_instr),
    .pc_i      (in_pc),
    .rs1_i     (in_rs1_data),
    .rs2_i     (in_rs2_data),
    .alu_sel_o (dec_sel),
    .op_a_o    (dec_op_a),
    .op_b_o    (dec_op_b),
    .rd_o      (dec_rd),
    .rd_we_o   (dec_rd_we),
    .illegal_o (dec_illegal)
  );

  assign in_ready = !valid_q || out_ready;

  // Flush wins over both transfers; a load while draining replaces the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      sel_q     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      illegal_q <= 1'b0;
      pc_q      <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      valid_q   <= 1'b1;
      sel_q     <= dec_sel;
      op_a_q    <= dec_op_a;
      op_b_q    <= dec_op_b;
      rd_q      <= dec_rd;
      rd_we_q   <= dec_rd_we;
      illegal_q <= dec_illegal;
      pc_q      <= in_pc;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign out_alu_sel = sel_q;
  assign out_op_a    = op_a_q;
  assign out_op_b    = op_b_q;
  assign out_rd      = rd_q;
  assign out_rd_we   = rd_we_q;
  assign out_illegal = illegal_q;
  assign out_pc      = pc_q;

endmodule
